// File: rtl/boot_mem_pkg.sv
// Shared types and constants for the boot-time / run-time unified RAM arbiter.
package boot_mem_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } boot_state_t;

    localparam int PORT_IF = 0;
    localparam int PORT_D  = 1;
    localparam int RAM_DW  = 32;

    // Saturating increment for the optional performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time is granted.
module rr_arb2
    import boot_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_last_r;   // 1 = data port won last, 0 = fetch port won last

    // Grant the sole requester, or alternate when both request.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = rr_last_r ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= 1'b1;
        end else if (gnt != 2'b00) begin
            rr_last_r <= gnt[PORT_D];
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/boot_mem_arbiter.sv
// Unified RAM owner: loader during boot, core held in reset, then fetch/data round-robin.
// Optional macro ARB_PERF_EN adds saturating grant/conflict counters.
module boot_mem_arbiter
    import boot_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    input  logic              ldr_we,
    input  logic              ldr_done,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_rst_n,
`ifdef ARB_PERF_EN
    output logic [31:0]       if_gnt_cnt,
    output logic [31:0]       d_gnt_cnt,
    output logic [31:0]       conflict_cnt,
`endif
    output logic              boot_err
);

    boot_state_t state_r, state_next_s;
    logic [3:0]  hold_cnt_r;
    logic        cpu_rst_n_r, boot_err_r, if_rvalid_r, d_rvalid_r;
    logic [1:0]  gnt_s;
    logic        unused_s;

    assign unused_s = ^{ldr_addr[31:ADDR_W+2], if_addr[31:ADDR_W+2], if_addr[1:0],
                        d_addr[31:ADDR_W+2], d_addr[1:0]};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == RUN),
        .req   ({d_req, if_req}),
        .gnt   (gnt_s)
    );

    assign if_gnt    = gnt_s[PORT_IF];
    assign d_gnt     = gnt_s[PORT_D];
    assign if_rvalid = if_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign cpu_rst_n = cpu_rst_n_r;
    assign boot_err  = boot_err_r;

    // Next-state logic: BOOT waits for the loader, HOLD counts, RUN is terminal.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: begin
                if (ldr_done) state_next_s = HOLD;
                else          state_next_s = BOOT;
            end
            HOLD: begin
                if (hold_cnt_r == 4'(RESET_HOLD - 1)) state_next_s = RUN;
                else                                  state_next_s = HOLD;
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = BOOT;
        endcase
    end

    // RAM port mux: loader in BOOT, arbiter winner in RUN, idle otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (state_r)
            BOOT: begin
                mem_en    = ldr_we;
                mem_we    = ldr_we;
                mem_be    = 4'hF;
                mem_addr  = ldr_addr[ADDR_W+1:2];
                mem_wdata = ldr_wdata;
            end
            RUN: begin
                if (gnt_s[PORT_D]) begin
                    mem_en    = 1'b1;
                    mem_we    = d_we;
                    mem_be    = d_be;
                    mem_addr  = d_addr[ADDR_W+1:2];
                    mem_wdata = d_wdata;
                end else if (gnt_s[PORT_IF]) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b0;
                    mem_be    = 4'hF;
                    mem_addr  = if_addr[ADDR_W+1:2];
                    mem_wdata = 32'h0;
                end else begin
                    mem_en    = 1'b0;
                end
            end
            default: mem_en = 1'b0;
        endcase
    end

    // State, hold counter, core reset, sticky error and read-return tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= BOOT;
            hold_cnt_r  <= 4'd0;
            cpu_rst_n_r <= 1'b0;
            boot_err_r  <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hold_cnt_r  <= (state_r == HOLD) ? hold_cnt_r + 4'd1 : 4'd0;
            cpu_rst_n_r <= (state_next_s == RUN);
            if_rvalid_r <= gnt_s[PORT_IF];
            d_rvalid_r  <= gnt_s[PORT_D] & ~d_we;
            // Loader writes outside BOOT are dropped; misaligned boot writes still land.
            if ((ldr_we && state_r != BOOT) ||
                (ldr_we && state_r == BOOT && ldr_addr[1:0] != 2'b00)) begin
                boot_err_r <= 1'b1;
            end else begin
                boot_err_r <= boot_err_r;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] if_gnt_cnt_r, d_gnt_cnt_r, conflict_cnt_r;

    assign if_gnt_cnt   = if_gnt_cnt_r;
    assign d_gnt_cnt    = d_gnt_cnt_r;
    assign conflict_cnt = conflict_cnt_r;

    // Saturating RUN-only grant and conflict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt_cnt_r   <= 32'h0;
            d_gnt_cnt_r    <= 32'h0;
            conflict_cnt_r <= 32'h0;
        end else begin
            if_gnt_cnt_r   <= gnt_s[PORT_IF] ? sat_inc(if_gnt_cnt_r) : if_gnt_cnt_r;
            d_gnt_cnt_r    <= gnt_s[PORT_D]  ? sat_inc(d_gnt_cnt_r)  : d_gnt_cnt_r;
            conflict_cnt_r <= (state_r == RUN && if_req && d_req) ?
                              sat_inc(conflict_cnt_r) : conflict_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed bench for boot_mem_arbiter with a behavioural single-port RAM (1-cycle read).
module tb_boot_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int RESET_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       ldr_addr, ldr_wdata;
    logic              ldr_we, ldr_done;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cpu_rst_n, boot_err;
`ifdef ARB_PERF_EN
    logic [31:0]       if_gnt_cnt, d_gnt_cnt, conflict_cnt;
`endif

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    boot_mem_arbiter #(.ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_we(ldr_we), .ldr_done(ldr_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_rst_n(cpu_rst_n),
`ifdef ARB_PERF_EN
        .if_gnt_cnt(if_gnt_cnt), .d_gnt_cnt(d_gnt_cnt), .conflict_cnt(conflict_cnt),
`endif
        .boot_err(boot_err)
    );

    // RAM macro model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ldr_write(input logic [31:0] a, input logic [31:0] w, input logic [ADDR_W-1:0] exp_wa);
        ldr_we = 1'b1; ldr_addr = a; ldr_wdata = w;
        #1;
        check_val("ldr_mem_we",   {31'd0, mem_we}, 32'd1);
        check_val("ldr_mem_be",   {28'd0, mem_be}, 32'hF);
        check_val("ldr_mem_addr", {22'd0, mem_addr}, {22'd0, exp_wa});
        check_val("ldr_mem_wdata", mem_wdata, w);
        tick();
        ldr_we = 1'b0;
    endtask

    initial begin
        logic [1:0]  exp_g [0:3];
        logic [31:0] exp_d [0:3];
        int n;
        rst_n = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0; ldr_we = 1'b0; ldr_done = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        d_addr = 32'h0; d_wdata = 32'h0;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_d[0] = 32'h0010_0093; exp_d[1] = 32'h0020_0113;
        exp_d[2] = 32'h0010_0093; exp_d[3] = 32'h0020_0113;

        // Reset values; requests in BOOT are never granted.
        if_req = 1'b1; d_req = 1'b1;
        #12;
        check_val("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("rst_boot_err",  {31'd0, boot_err}, 32'd0);
        check_val("rst_gnts",      {30'd0, d_gnt, if_gnt}, 32'd0);
        check_val("rst_mem_en",    {31'd0, mem_en}, 32'd0);
        check_val("rst_rvalids",   {30'd0, d_rvalid, if_rvalid}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: program load, then timed core reset release.
        ldr_write(32'h0000_0000, 32'h0010_0093, 10'd0);
        ldr_write(32'h0000_0004, 32'h0020_0113, 10'd1);
        ldr_write(32'h0000_0010, 32'h1234_5678, 10'd4);
        ldr_done = 1'b1;
        tick();
        n = 1;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        check_val("hold_mem_en", {31'd0, mem_en}, 32'd0);
        check_val("hold_gnts",   {30'd0, d_gnt, if_gnt}, 32'd0);
        check_val("hold_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        while (cpu_rst_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val("cpu_rst_n_delay", n, RESET_HOLD + 1);
        check_val("run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

        // Test 2: lone fetch of word 1.
        if_req = 1'b1; if_addr = 32'h0000_0004;
        #1;
        check_val("t2_if_gnt",   {30'd0, d_gnt, if_gnt}, 32'd1);
        check_val("t2_mem_addr", {22'd0, mem_addr}, 32'd1);
        check_val("t2_mem_we",   {31'd0, mem_we}, 32'd0);
        check_val("t2_mem_be",   {28'd0, mem_be}, 32'hF);
        tick();
        if_req = 1'b0;
        check_val("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("t2_if_rdata",  if_rdata, 32'h0020_0113);

        // Test 4: partial data write then read back of word 4.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0010; d_wdata = 32'hAAAA_5555;
        #1;
        check_val("t4_d_gnt",    {30'd0, d_gnt, if_gnt}, 32'd2);
        check_val("t4_mem_we",   {31'd0, mem_we}, 32'd1);
        check_val("t4_mem_be",   {28'd0, mem_be}, 32'h3);
        check_val("t4_mem_addr", {22'd0, mem_addr}, 32'd4);
        tick();
        check_val("t4_wr_no_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
        d_we = 1'b0;
        tick();
        d_req = 1'b0;
        check_val("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_val("t4_d_rdata",  d_rdata, 32'h1234_5555);

        // Test 3: both ports held four cycles; data won last so fetch goes first.
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req  = 1'b1; d_addr  = 32'h0000_0004;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val($sformatf("t3_gnt%0d", k), {30'd0, d_gnt, if_gnt}, {30'd0, exp_g[k]});
            tick();
            if (k == 3) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            check_val($sformatf("t3_rvalid%0d", k), {30'd0, d_rvalid, if_rvalid}, {30'd0, exp_g[k]});
            check_val($sformatf("t3_rdata%0d", k), exp_g[k][0] ? if_rdata : d_rdata, exp_d[k]);
        end
`ifdef ARB_PERF_EN
        check_val("perf_conflict", conflict_cnt, 32'd4);
        check_val("perf_if_gnt",   if_gnt_cnt, 32'd3);
        check_val("perf_d_gnt",    d_gnt_cnt, 32'd4);
`endif
        tick();
        check_val("t3_idle_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);

        // Test 5: loader write in RUN is dropped and flags an error; ldr_done fall ignored.
        ldr_we = 1'b1; ldr_addr = 32'h0; ldr_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("t5_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        ldr_we = 1'b0; ldr_done = 1'b0;
        check_val("t5_boot_err", {31'd0, boot_err}, 32'd1);
        tick(); tick();
        check_val("t5_boot_err_sticky", {31'd0, boot_err}, 32'd1);
        check_val("t5_cpu_rst_n_kept",  {31'd0, cpu_rst_n}, 32'd1);

        // Reset during HOLD returns to BOOT.
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("t5_rst_boot_err",  {31'd0, boot_err}, 32'd0);
        tick();
        rst_n = 1'b1; ldr_done = 1'b1;
        tick(); tick();
        check_val("t5_hold_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        rst_n = 1'b0; ldr_done = 1'b0;
        #1;
        check_val("t5_hold_rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_val("t5_still_held", {31'd0, cpu_rst_n}, 32'd0);
        // Back in BOOT: misaligned loader write lands on word 8 and flags an error.
        ldr_write(32'h0000_0021, 32'h0BAD_F00D, 10'd8);
        check_val("t5_misalign_err", {31'd0, boot_err}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
